instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the program ROM: owns the PC, drives the ROM byte address, captures the returned word.
//  Buffers fetched words in a 2-entry prefetch queue and hands them to decode over a valid/ready handshake.
//  Accepts redirects (branch/jump/jr) from execute; a redirect flushes the queue and restarts fetch at the target.
//  Flags misaligned redirect targets and PCs outside the ROM window.
// PARAMETERS
//  DATA_WIDTH    32            width of PC, address and instruction
//  MEMORY_DEPTH  32            ROM depth in words; defines the valid fetch window
//  RESET_PC      32'h0040_0000 byte address of the first instruction (ROM word 0)
// PORTS
//  clk             in   1   rising-edge clock
//  reset           in   1   synchronous, active-low reset
//  redirect_valid  in   1   1 = load PC from redirect_target this cycle
//  redirect_target in   32  byte address of the new fetch PC
//  fetch_pc        out  32  byte address to the program ROM Address input
//  fetch_instr     in   32  ROM Instruction output; combinational from fetch_pc, same cycle
//  out_valid       out  1   queue head holds a valid instruction
//  out_ready       in   1   decode accepts head this cycle
//  out_instr       out  32  head instruction word
//  out_pc          out  32  byte address of head instruction
//  out_pc_plus4    out  32  out_pc + 4 (mod 2^32), for link/branch base
//  occupancy       out  2   queue entries in use, 0..2
//  misalign_err    out  1   sticky: a redirect target had bits [1:0] != 0
//  range_err       out  1   sticky: fetch_pc left [RESET_PC, RESET_PC + 4*MEMORY_DEPTH)
// BEHAVIOUR
//  Reset (reset==0 at posedge): PC=RESET_PC, queue empty, out_valid=0, occupancy=0, both errors=0;
//   out_instr/out_pc/out_pc_plus4 = 0. Reset wins over every other input.
//  fetch_pc = PC (registered). Word at fetch_pc is sampled on the same edge that advances PC.
//  pop  = out_valid & out_ready.
//  push = !redirect_valid & in_range(PC) & (occupancy<2 | pop).
//  On push: queue tail <= {PC, fetch_instr}; PC <= PC+4 (mod 2^32).
//  No push and no redirect: PC holds (stall on full queue or out-of-range PC).
//  Latency: word fetched at edge n is visible at the head after edge n, when it is the only entry.
//   Steady throughput is 1 instr/cycle with out_ready=1.
//  Queue: 2-entry FIFO, head at out_*. Simultaneous push+pop at occupancy 2 is legal; occupancy stays 2.
//   Pop at occupancy 0 is impossible (out_valid=0).
//  Redirect (priority over push):
//   - a pop in the same cycle counts as accepted;
//   - all remaining entries are discarded, occupancy<=0, out_valid<=0;
//   - PC <= {redirect_target[31:2],2'b00}; no fetch that cycle;
//   - first fetched word from the target is at the head one cycle after the next edge.
//  misalign_err <= 1 when redirect_valid & |redirect_target[1:0]; the address is still used, truncated.
//  range_err <= 1 when PC is out of window and no redirect is pending. PC holds until a redirect.
//   PC+4 wrap from 32'hFFFF_FFFC to 0 is out of window.
//  Errors clear only by reset. Back-to-back redirects: the last one wins; each one flushes.
//  Reset mid-operation discards queue contents with no partial handshake.
// TESTING
//  Reset then out_ready=1, ROM word i = i: fetch_pc 0x400000,0x400004,...; out_valid from cycle 2;
//   out_instr 0,1,2 at 1/cycle; out_pc_plus4 = out_pc+4.
//  out_ready=0 for 5 cycles: occupancy reaches 2, fetch_pc frozen at 0x400008.
//   Releasing ready drains in order with no loss or duplication.
//  Redirect to 0x400040 while occupancy=2 and out_ready=1: head accepted; other entry dropped;
//   next out_pc = 0x400040.
//  Redirect to 0x400042: misalign_err=1; fetch_pc=0x400040.
//  Redirect to 0x400080 with MEMORY_DEPTH=32: range_err=1, out_valid stays 0, fetch_pc holds;
//   redirect to 0x400000 resumes fetch with range_err still 1.
//  reset=0 for one cycle mid-stream at occupancy 2: next cycle occupancy=0,
//   fetch_pc=0x400000, both errors 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage sitting directly in front of the program ROM.
// Owns the PC, drives the ROM byte address, captures the returned word into a
// 2-entry prefetch queue and presents the queue head to decode.
//
// Handshake (out_*): an entry transfers on a rising edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready. While out_valid
// is 1 and no transfer happens, out_instr/out_pc/out_pc_plus4 stay stable,
// unless a redirect or reset flushes the queue.
module instruction_fetch_unit #(
  parameter int unsigned     DATA_WIDTH   = 32,
  parameter int unsigned     MEMORY_DEPTH = 32,
  parameter logic [31:0]     RESET_PC     = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  output logic [DATA_WIDTH-1:0] fetch_pc,
  input  logic [DATA_WIDTH-1:0] fetch_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_pc_plus4,
  output logic [1:0]            occupancy,
  output logic                  misalign_err,
  output logic                  range_err
);

  localparam logic [DATA_WIDTH-1:0] BASE_PC      = DATA_WIDTH'(RESET_PC);
  localparam logic [DATA_WIDTH-1:0] WINDOW_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-1:0] PC_STEP      = DATA_WIDTH'(4);

  // Architectural PC and sticky error flags
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  misalign_q, misalign_d;
  logic                  range_q, range_d;

  // Queue: head slot drives out_*, tail slot holds the second entry
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_pc_q, head_pc_d;
  logic [DATA_WIDTH-1:0] head_pc4_q, head_pc4_d;
  logic [DATA_WIDTH-1:0] head_instr_q, head_instr_d;
  logic [DATA_WIDTH-1:0] tail_pc_q, tail_pc_d;
  logic [DATA_WIDTH-1:0] tail_pc4_q, tail_pc4_d;
  logic [DATA_WIDTH-1:0] tail_instr_q, tail_instr_d;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] pc_offset;
  logic                  pc_in_range;
  logic                  pop;
  logic                  push;

  // Window test, fetch handshake decisions and PC increment
  always_comb begin
    pc_plus4    = pc_q + PC_STEP;
    // Unsigned offset from the window base: anything below the base wraps
    // to a huge value, so one compare covers both window edges.
    pc_offset   = pc_q - BASE_PC;
    pc_in_range = (pc_offset < WINDOW_BYTES);
    pop         = (occ_q != 2'd0) && out_ready;
    push        = !redirect_valid && pc_in_range && ((occ_q != 2'd2) || pop);
  end

  // Next-state for PC, queue slots and error flags
  always_comb begin
    pc_d         = pc_q;
    misalign_d   = misalign_q;
    range_d      = range_q;
    occ_d        = occ_q;
    head_pc_d    = head_pc_q;
    head_pc4_d   = head_pc4_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_pc4_d   = tail_pc4_q;
    tail_instr_d = tail_instr_q;

    if (redirect_valid) begin
      // Any same-cycle pop has already been taken by decode; everything
      // left is stale. The target is word-aligned by truncation.
      occ_d      = 2'd0;
      pc_d       = {redirect_target[DATA_WIDTH-1:2], 2'b00};
      misalign_d = misalign_q | (|redirect_target[1:0]);
    end else begin
      range_d = range_q | !pc_in_range;
      if (push) begin
        pc_d = pc_plus4;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};

      // New word lands at the head when the head is empty or being vacated
      // with nothing behind it; otherwise it goes to the tail.
      if (push && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop))) begin
        head_pc_d    = pc_q;
        head_pc4_d   = pc_plus4;
        head_instr_d = fetch_instr;
      end
      if ((occ_q == 2'd2) && pop) begin
        head_pc_d    = tail_pc_q;
        head_pc4_d   = tail_pc4_q;
        head_instr_d = tail_instr_q;
      end
      if (push && (((occ_q == 2'd1) && !pop) || (occ_q == 2'd2))) begin
        tail_pc_d    = pc_q;
        tail_pc4_d   = pc_plus4;
        tail_instr_d = fetch_instr;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= BASE_PC;
      misalign_q   <= 1'b0;
      range_q      <= 1'b0;
      occ_q        <= 2'd0;
      head_pc_q    <= '0;
      head_pc4_q   <= '0;
      head_instr_q <= '0;
      tail_pc_q    <= '0;
      tail_pc4_q   <= '0;
      tail_instr_q <= '0;
    end else begin
      pc_q         <= pc_d;
      misalign_q   <= misalign_d;
      range_q      <= range_d;
      occ_q        <= occ_d;
      head_pc_q    <= head_pc_d;
      head_pc4_q   <= head_pc4_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_pc4_q   <= tail_pc4_d;
      tail_instr_q <= tail_instr_d;
    end
  end

  // Output mapping; head slot carries its own PC+4 so it reads 0 after reset
  always_comb begin
    fetch_pc     = pc_q;
    out_valid    = (occ_q != 2'd0);
    out_instr    = head_instr_q;
    out_pc       = head_pc_q;
    out_pc_plus4 = head_pc4_q;
    occupancy    = occ_q;
    misalign_err = misalign_q;
    range_err    = range_q;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: ROM model, reference model with an
// expected queue of accepted instructions, negedge monitor, directed and
// randomized stimulus, final report.
module tb_instruction_fetch_unit;

  localparam int unsigned MEMORY_DEPTH = 32;
  localparam logic [31:0] RESET_PC     = 32'h0040_0000;

  // Clock and reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [1:0]  occupancy;
  logic        misalign_err;
  logic        range_err;

  instruction_fetch_unit #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .RESET_PC    (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .occupancy      (occupancy),
    .misalign_err   (misalign_err),
    .range_err      (range_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= RESET_PC) && (a < RESET_PC + 4 * MEMORY_DEPTH);
  endfunction

  // Program ROM: combinational read of the word at fetch_pc
  logic [31:0] rom [MEMORY_DEPTH];
  initial begin
    for (int i = 0; i < MEMORY_DEPTH; i++) rom[i] = (i < 4) ? i : $urandom;
  end

  always_comb begin
    if (in_win(fetch_pc)) fetch_instr = rom[int'((fetch_pc - RESET_PC) >> 2)];
    else                  fetch_instr = 32'hBAD0_0000 ^ fetch_pc;
  end

  // Reference model: PC, entry count, sticky errors, expected accepted stream
  logic [95:0] exp_q[$];
  logic [31:0] m_pc;
  int          m_occ;
  bit          m_mis;
  bit          m_rng;
  bit          mon_en = 1'b0;

  always @(posedge clk) begin
    bit m_pop;
    bit m_push;
    if (!reset) begin
      m_pc   = RESET_PC;
      m_occ  = 0;
      m_mis  = 1'b0;
      m_rng  = 1'b0;
      exp_q.delete();
      mon_en = 1'b1;
    end else if (mon_en) begin
      m_pop = (m_occ > 0) && out_ready;
      if (redirect_valid) begin
        exp_q.delete();
        m_occ = 0;
        if (redirect_target % 4 != 0) m_mis = 1'b1;
        m_pc = redirect_target - (redirect_target % 4);
      end else begin
        if (!in_win(m_pc)) m_rng = 1'b1;
        m_push = in_win(m_pc) && (m_occ < 2 || m_pop);
        if (m_push) begin
          exp_q.push_back({m_pc, m_pc + 32'd4, rom[int'((m_pc - RESET_PC) / 4)]});
          m_pc = m_pc + 32'd4;
        end
        m_occ = m_occ + int'(m_push) - int'(m_pop);
      end
    end
  end

  // Scoreboard monitor: checks every handshake and the visible state
  always @(negedge clk) begin
    logic [95:0] e;
    if (mon_en) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("pop_with_empty_expected", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e[95:64]);
          chk("out_pc_plus4", out_pc_plus4, e[63:32]);
          chk("out_instr", out_instr, e[31:0]);
        end
      end
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_occ > 0});
      chk("occupancy", {30'd0, occupancy}, 32'(m_occ));
      chk("fetch_pc", fetch_pc, m_pc);
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
      chk("range_err", {31'd0, range_err}, {31'd0, m_rng});
    end
  end

  // Driver: apply one cycle of inputs, return just after the edge
  task automatic step(input bit rv, input logic [31:0] tgt, input bit rdy, input bit rst_n = 1'b1);
    redirect_valid  = rv;
    redirect_target = tgt;
    out_ready       = rdy;
    reset           = rst_n;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, rdy);
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return RESET_PC + 4 * $urandom_range(0, MEMORY_DEPTH - 1);
      6:                return RESET_PC + $urandom_range(0, 4 * MEMORY_DEPTH - 1);
      7:                return RESET_PC + 4 * MEMORY_DEPTH - 4 * $urandom_range(1, 2);
      8:                return RESET_PC + 4 * MEMORY_DEPTH + 4 * $urandom_range(0, 3);
      default:          return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFC : 32'h0000_0000;
    endcase
  endfunction

  initial begin
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    out_ready       = 1'b0;
    reset           = 1'b0;

    // Reset values
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("rst_fetch_pc", fetch_pc, 32'h0040_0000);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_pc_plus4", out_pc_plus4, 32'd0);
    chk("rst_errors", {30'd0, misalign_err, range_err}, 32'd0);

    // Streaming at one instruction per cycle
    step(1'b0, 32'd0, 1'b1);
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_instr", out_instr, 32'd0);
    chk("first_pc", out_pc, 32'h0040_0000);
    chk("first_fetch_pc", fetch_pc, 32'h0040_0004);
    step(1'b0, 32'd0, 1'b1);
    chk("second_instr", out_instr, 32'd1);
    idle(6, 1'b1);

    // Back-pressure from reset: queue fills, PC freezes, then drains
    step(1'b0, 32'd0, 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("stall_occupancy", {30'd0, occupancy}, 32'd2);
    chk("stall_fetch_pc", fetch_pc, 32'h0040_0008);
    idle(6, 1'b1);

    // Redirect while full with a same-cycle pop
    idle(2, 1'b0);
    chk("pre_redirect_occ", {30'd0, occupancy}, 32'd2);
    step(1'b1, 32'h0040_0040, 1'b1);
    chk("redirect_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("redirect_fetch_pc", fetch_pc, 32'h0040_0040);
    step(1'b0, 32'd0, 1'b1);
    chk("redirect_head_pc", out_pc, 32'h0040_0040);
    idle(3, 1'b1);

    // Misaligned target is truncated and flagged
    step(1'b1, 32'h0040_0042, 1'b1);
    chk("misalign_flag", {31'd0, misalign_err}, 32'd1);
    chk("misalign_fetch_pc", fetch_pc, 32'h0040_0040);
    idle(3, 1'b1);

    // Out-of-window target: flag, no fetch, PC holds until next redirect
    step(1'b1, 32'h0040_0080, 1'b1);
    idle(3, 1'b1);
    chk("range_flag", {31'd0, range_err}, 32'd1);
    chk("range_no_valid", {31'd0, out_valid}, 32'd0);
    chk("range_pc_hold", fetch_pc, 32'h0040_0080);
    step(1'b1, 32'h0040_0000, 1'b1);
    idle(2, 1'b1);
    chk("resume_valid", {31'd0, out_valid}, 32'd1);
    chk("resume_range_sticky", {31'd0, range_err}, 32'd1);

    // Fetch up to the top of the window and stop there
    step(1'b1, RESET_PC + 4 * MEMORY_DEPTH - 8, 1'b1);
    idle(4, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) step(1'b1, rand_target(), $urandom_range(0, 3) != 0);
      else                           step(1'b0, 32'd0, $urandom_range(0, 3) != 0);
    end

    // Reset in the middle of a full queue
    step(1'b1, 32'h0040_0002, 1'b1);
    idle(3, 1'b0);
    chk("midrst_pre_occ", {30'd0, occupancy}, 32'd2);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("midrst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("midrst_fetch_pc", fetch_pc, 32'h0040_0000);
    chk("midrst_errors", {30'd0, misalign_err, range_err}, 32'd0);
    idle(4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
